nes_line_buffer: RTL and testbench
==================================

Name: nes_line_buffer

Overview:
- Ping-pong scanline buffer directly upstream of the VGA scaler.
- Accepts the PPU's 256-pixel-per-line RGB stream through a valid/ready handshake and stores each line in one of two banks.
- Serves the VGA scaler's random-access pixel pointer with zero latency from the other bank, so each NES line is held steady for the two VGA lines that display it.
- Runs entirely in the 12.5 MHz pixel clock domain.

Parameters:
- WIDTH, 256, pixels per NES line (bank depth).
- HEIGHT, 240, NES lines per frame.
- RGB_W, 9, pixel width (3 bits each R, G, B).

Ports:
- pix_clk  in  1  12.5 MHz pixel clock.
- reset  in  1  asynchronous, active-high reset.
- ppu_rgb  in  RGB_W  producer pixel.
- ppu_valid  in  1  ppu_rgb valid.
- ppu_sof  in  1  qualifies the current pixel as frame pixel (0,0).
- ppu_ready  out  1  buffer can accept a pixel this cycle.
- pix_ptr_x  in  8  display column requested by the scaler.
- pix_ptr_y  in  8  display NES line requested by the scaler (held at 0 outside the visible area).
- rgb_buf  out  RGB_W  pixel at pix_ptr_x from the read bank.
- underrun  out  1  sticky: reader advanced before the write bank was full.
- sync_err  out  1  sticky: SOF misaligned, or line tag mismatch at swap.
- clr_status  in  1  synchronous clear of underrun and sync_err.

Behaviour:
- Clocking and reset:
  - One clock, pix_clk.
  - reset is asynchronous and active-high; all registers clear immediately, including mid-line.
- Storage:
  - Two banks of WIDTH x RGB_W, built as LUT/register arrays with asynchronous read.
  - Bank contents are not reset.
- Reset values:
  - state=IDLE, rbank=0, wbank=1, wx=0, wy=0, tag=0, rvalid=0, prev_y=0.
  - underrun=0, sync_err=0, rgb_buf=0.
- Read side (combinational):
  - rgb_buf = rvalid ? bank[rbank][pix_ptr_x] : 0.
  - Zero-cycle latency: the scaler samples rgb_buf in the same cycle it drives pix_ptr_x.
- Reader advance:
  - prev_y <= pix_ptr_y every cycle.
  - advance = (pix_ptr_y != prev_y), a single-cycle pulse.
  - The 239->0 transition at vertical front porch counts as an advance. Line 0 is displayed after that transition and held through vblank.
- Write FSM:
  - IDLE:
    - ppu_ready=1; pixels without ppu_sof are accepted and discarded.
    - Accepted SOF pixel: write bank[wbank][0], wx<=1, wy<=0, go to FILL.
  - FILL:
    - ppu_ready=1; each accepted pixel writes bank[wbank][wx], then wx++.
    - Accept at wx=WIDTH-1: tag<=wy, wx<=0, wy<=(wy==HEIGHT-1)?0:wy+1, go to FULL.
  - FULL:
    - ppu_ready=0.
    - On advance: swap (rbank<=wbank, wbank<=rbank), rvalid<=1, go to FILL.
    - If tag != pix_ptr_y at the swap, set sync_err. The swap still occurs.
- Underrun:
  - advance while in IDLE or FILL: no swap; the old line repeats and underrun is set.
  - Writing continues into the same bank.
- Simultaneous final accept and advance (same cycle): treated as full; the swap occurs that cycle and the FSM goes to FILL with the new write bank.
- SOF handling:
  - Accepted ppu_sof in FILL with (wx,wy) != (0,0): set sync_err, realign (pixel written at address 0, wx<=1, wy<=0).
  - SOF exactly at (0,0) is normal.
- clr_status:
  - Clears both sticky flags on the next edge.
  - A set condition in the same cycle wins.
- Widths:
  - wx is 8 bits and wy is 8 bits, with explicit compares to WIDTH-1 and HEIGHT-1 (no reliance on natural wrap for wy).

Decomposition:
- Shared package nes_video_pkg:
  - constants NES_WIDTH=256, NES_HEIGHT=240, RGB_W=9;
  - typedef rgb_t (logic [8:0]);
  - enum wr_state_t {IDLE, FILL, FULL}.
- One natural sub-module, line_bank_ram: one WIDTH x RGB_W bank with a synchronous write port and an asynchronous read port, instantiated twice.

Test Plan:
- Reset, then stream line 0 with SOF (pixel i = i[8:0]), then step pix_ptr_y 0->1 -> swap occurs; pix_ptr_y=1, pix_ptr_x=37 gives rgb_buf=37 in the same cycle. Before the swap, rgb_buf=0.
- Fill the write bank completely without any advance -> ppu_ready=0 after the 256th accept; further ppu_valid causes no writes; on the next advance ppu_ready returns to 1 within 1 cycle.
- Advance pix_ptr_y while only 100 pixels of the next line are written -> no swap, rgb_buf still shows the previous line, underrun=1 until clr_status.
- Drive the last pixel (wx=255) in the same cycle pix_ptr_y changes -> swap that cycle; the new line is visible on the next cycle and underrun stays 0.
- SOF asserted at wx=50, wy=3 -> sync_err=1; the pixel is stored at address 0 of the current write bank, and the line completes 255 pixels later with tag 0.
- Assert reset mid-line (wx=128) -> ppu_ready=1 (IDLE) and rgb_buf=0 immediately, without a clock edge; non-SOF pixels are discarded until the next SOF.

Source files
------------

// File: rtl/nes_video_pkg.sv
// rtl/nes_video_pkg.sv - shared NES video constants, pixel type and line-writer states
package nes_video_pkg;
  localparam int NES_WIDTH  = 256;
  localparam int NES_HEIGHT = 240;
  localparam int RGB_W      = 9;

  typedef logic [RGB_W-1:0] rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL
  } wr_state_t;
endpackage

// File: rtl/line_bank_ram.sv
// rtl/line_bank_ram.sv - one scanline bank: synchronous write port, asynchronous read port
module line_bank_ram #(
  parameter int DEPTH = 256,
  parameter int DW    = 9,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/nes_line_buffer.sv
// rtl/nes_line_buffer.sv - ping-pong scanline buffer between the PPU stream and the VGA scaler
module nes_line_buffer #(
  parameter int WIDTH  = nes_video_pkg::NES_WIDTH,
  parameter int HEIGHT = nes_video_pkg::NES_HEIGHT,
  parameter int RGB_W  = nes_video_pkg::RGB_W
) (
  input  logic             pix_clk,
  input  logic             reset,
  input  logic [RGB_W-1:0] ppu_rgb,
  input  logic             ppu_valid,
  input  logic             ppu_sof,
  output logic             ppu_ready,
  input  logic [7:0]       pix_ptr_x,
  input  logic [7:0]       pix_ptr_y,
  output logic [RGB_W-1:0] rgb_buf,
  output logic             underrun,
  output logic             sync_err,
  input  logic             clr_status
);
  import nes_video_pkg::*;

  wr_state_t        state_q, state_d;
  logic             rbank_q, rbank_d, wbank_q, wbank_d;
  logic             rvalid_q, rvalid_d;
  logic             underrun_q, underrun_d, sync_err_q, sync_err_d;
  logic [7:0]       wx_q, wx_d, wy_q, wy_d, tag_q, tag_d, prev_y_q;
  logic             advance, accept, swap, wr_en;
  logic [7:0]       wr_addr;
  logic [RGB_W-1:0] rd0, rd1;

  assign advance   = (pix_ptr_y != prev_y_q);
  assign ppu_ready = (state_q != FULL);
  assign accept    = ppu_valid && ppu_ready;

  always_comb begin
    state_d    = state_q;
    rbank_d    = rbank_q;
    wbank_d    = wbank_q;
    rvalid_d   = rvalid_q;
    wx_d       = wx_q;
    wy_d       = wy_q;
    tag_d      = tag_q;
    underrun_d = clr_status ? 1'b0 : underrun_q;
    sync_err_d = clr_status ? 1'b0 : sync_err_q;
    swap       = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = wx_q;
    case (state_q)
      IDLE: begin
        if (accept && ppu_sof) begin
          wr_en   = 1'b1;
          wr_addr = 8'd0;
          wx_d    = 8'd1;
          wy_d    = 8'd0;
          state_d = FILL;
        end
        if (advance) underrun_d = 1'b1;
      end
      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (ppu_sof && (wx_q != 8'd0 || wy_q != 8'd0)) begin
            sync_err_d = 1'b1;
            wr_addr    = 8'd0;
            wx_d       = 8'd1;
            wy_d       = 8'd0;
          end else if (wx_q == 8'(WIDTH-1)) begin
            tag_d   = wy_q;
            wx_d    = 8'd0;
            wy_d    = (wy_q == 8'(HEIGHT-1)) ? 8'd0 : wy_q + 8'd1;
            state_d = FULL;
          end else begin
            wx_d = wx_q + 8'd1;
          end
        end
        // A line finishing in the same cycle the reader moves on counts as full
        if (advance) begin
          if (state_d == FULL) swap = 1'b1;
          else                 underrun_d = 1'b1;
        end
      end
      FULL: begin
        if (advance) swap = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (swap) begin
      rbank_d  = wbank_q;
      wbank_d  = rbank_q;
      rvalid_d = 1'b1;
      state_d  = FILL;
      if (tag_d != pix_ptr_y) sync_err_d = 1'b1;
    end
  end

  always_ff @(posedge pix_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rbank_q    <= 1'b0;
      wbank_q    <= 1'b1;
      rvalid_q   <= 1'b0;
      wx_q       <= 8'd0;
      wy_q       <= 8'd0;
      tag_q      <= 8'd0;
      prev_y_q   <= 8'd0;
      underrun_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rbank_q    <= rbank_d;
      wbank_q    <= wbank_d;
      rvalid_q   <= rvalid_d;
      wx_q       <= wx_d;
      wy_q       <= wy_d;
      tag_q      <= tag_d;
      prev_y_q   <= pix_ptr_y;
      underrun_q <= underrun_d;
      sync_err_q <= sync_err_d;
    end
  end

  line_bank_ram #(.DEPTH(WIDTH), .DW(RGB_W)) u_bank0 (
    .clk   (pix_clk),
    .we    (wr_en && !wbank_q),
    .waddr (wr_addr),
    .wdata (ppu_rgb),
    .raddr (pix_ptr_x),
    .rdata (rd0)
  );

  line_bank_ram #(.DEPTH(WIDTH), .DW(RGB_W)) u_bank1 (
    .clk   (pix_clk),
    .we    (wr_en && wbank_q),
    .waddr (wr_addr),
    .wdata (ppu_rgb),
    .raddr (pix_ptr_x),
    .rdata (rd1)
  );

  assign rgb_buf  = rvalid_q ? (rbank_q ? rd1 : rd0) : '0;
  assign underrun = underrun_q;
  assign sync_err = sync_err_q;
endmodule

// File: tb/tb_nes_line_buffer.sv
// tb/tb_nes_line_buffer.sv - self-checking bench for nes_line_buffer
module tb_nes_line_buffer;
  logic       pix_clk = 1'b0;
  logic       reset;
  logic [8:0] ppu_rgb;
  logic       ppu_valid, ppu_sof, ppu_ready;
  logic [7:0] pix_ptr_x, pix_ptr_y;
  logic [8:0] rgb_buf;
  logic       underrun, sync_err, clr_status;

  int passed = 0;
  int total  = 0;

  always #5 pix_clk = ~pix_clk;

  nes_line_buffer dut (
    .pix_clk    (pix_clk),
    .reset      (reset),
    .ppu_rgb    (ppu_rgb),
    .ppu_valid  (ppu_valid),
    .ppu_sof    (ppu_sof),
    .ppu_ready  (ppu_ready),
    .pix_ptr_x  (pix_ptr_x),
    .pix_ptr_y  (pix_ptr_y),
    .rgb_buf    (rgb_buf),
    .underrun   (underrun),
    .sync_err   (sync_err),
    .clr_status (clr_status)
  );

  // Reference model: the line being written, the line on display, flags.
  int m_wr[256];
  int m_disp[256];
  bit m_idle, m_full, m_rvalid, m_under, m_sync;
  int m_cnt, m_line, m_tag, m_prev_y;

  function automatic void m_reset();
    m_idle = 1; m_full = 0; m_rvalid = 0; m_under = 0; m_sync = 0;
    m_cnt = 0; m_line = 0; m_tag = 0; m_prev_y = 0;
  endfunction

  function automatic void m_step();
    bit adv, acc;
    adv = (int'(pix_ptr_y) != m_prev_y);
    acc = ppu_valid && !m_full;
    if (clr_status) begin m_under = 0; m_sync = 0; end
    if (acc) begin
      if (m_idle) begin
        if (ppu_sof) begin m_wr[0] = ppu_rgb; m_cnt = 1; m_line = 0; m_idle = 0; end
      end else if (ppu_sof && (m_cnt != 0 || m_line != 0)) begin
        m_sync = 1; m_wr[0] = ppu_rgb; m_cnt = 1; m_line = 0;
      end else begin
        m_wr[m_cnt] = ppu_rgb;
        m_cnt++;
        if (m_cnt == 256) begin
          m_tag = m_line; m_line = (m_line + 1) % 240; m_cnt = 0; m_full = 1;
        end
      end
    end
    if (adv) begin
      if (m_full) begin
        if (m_tag != int'(pix_ptr_y)) m_sync = 1;
        m_disp = m_wr; m_rvalid = 1; m_full = 0;
      end else begin
        m_under = 1;
      end
    end
    m_prev_y = pix_ptr_y;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Inputs are set just after a rising edge; outputs compared mid-cycle.
  task automatic tick();
    #1;
    chk("ready", ppu_ready, !m_full);
    chk("rgb_buf", rgb_buf, m_rvalid ? m_disp[pix_ptr_x] : 0);
    chk("underrun", underrun, m_under);
    chk("sync_err", sync_err, m_sync);
    m_step();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic push(input logic [8:0] v, input bit s);
    ppu_valid = 1; ppu_rgb = v; ppu_sof = s;
    tick();
    ppu_valid = 0; ppu_sof = 0;
  endtask

  function automatic logic [8:0] pix(input int k, input int i);
    return 9'((i + 61 * k) % 512);
  endfunction

  task automatic clear_flags();
    clr_status = 1; tick(); clr_status = 0;
  endtask

  typedef struct {
    logic [7:0] x;
    logic [8:0] exp;
  } rd_vec_t;

  initial begin
    rd_vec_t tbl[5];
    tbl[0] = '{8'd37, 9'd37};
    tbl[1] = '{8'd0, 9'd0};
    tbl[2] = '{8'd255, 9'd255};
    tbl[3] = '{8'd128, 9'd128};
    tbl[4] = '{8'd1, 9'd1};

    reset = 1; ppu_rgb = 0; ppu_valid = 0; ppu_sof = 0;
    pix_ptr_x = 0; pix_ptr_y = 0; clr_status = 0;
    m_reset();
    @(posedge pix_clk); @(posedge pix_clk); #1;
    chk("rst_ready", ppu_ready, 1);
    chk("rst_rgb", rgb_buf, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_sync", sync_err, 0);
    reset = 0;

    // Line 0 with SOF, then swap on 0->1
    push(pix(0, 0), 1);
    for (int i = 1; i < 256; i++) push(pix(0, i), 0);
    pix_ptr_x = 37; #1;
    chk("pre_swap_rgb", rgb_buf, 0);
    chk("full_ready", ppu_ready, 0);
    pix_ptr_y = 1;
    tick();
    chk("swap_rgb37", rgb_buf, 37);
    for (int t = 0; t < 5; t++) begin
      pix_ptr_x = tbl[t].x; #1;
      chk("tbl_rgb", rgb_buf, tbl[t].exp);
    end
    chk("tag0_vs_y1_sync", sync_err, 1);
    clear_flags();
    chk("clr_sync", sync_err, 0);

    // Line 1 fills the bank with no advance; extra pixels must be refused
    for (int i = 0; i < 255; i++) push(pix(1, i), 0);
    chk("ready_255", ppu_ready, 1);
    push(pix(1, 255), 0);
    chk("ready_256", ppu_ready, 0);
    for (int i = 0; i < 3; i++) push(9'h1AA, 0);
    pix_ptr_x = 0; pix_ptr_y = 2;
    tick();
    chk("ready_after_adv", ppu_ready, 1);
    chk("line1_x0", rgb_buf, pix(1, 0));
    pix_ptr_x = 255; #1;
    chk("line1_x255", rgb_buf, pix(1, 255));

    // Underrun: advance with only 100 pixels of line 2 written
    for (int i = 0; i < 100; i++) push(pix(2, i), 0);
    pix_ptr_y = 3; pix_ptr_x = 10;
    tick();
    chk("underrun_set", underrun, 1);
    chk("underrun_old_line", rgb_buf, pix(1, 10));
    tick(); tick();
    chk("underrun_sticky", underrun, 1);
    clear_flags();
    chk("underrun_clr", underrun, 0);

    // Last pixel coincides with the advance
    for (int i = 100; i < 255; i++) push(pix(2, i), 0);
    pix_ptr_y = 4;
    push(pix(2, 255), 0);
    pix_ptr_x = 255; #1;
    chk("sim_swap_x255", rgb_buf, pix(2, 255));
    pix_ptr_x = 7; #1;
    chk("sim_swap_x7", rgb_buf, pix(2, 7));
    chk("sim_swap_no_underrun", underrun, 0);
    clear_flags();

    // Misplaced SOF at wx=50, wy=3
    for (int i = 0; i < 50; i++) push(pix(3, i), 0);
    push(9'h155, 1);
    chk("sof_sync_err", sync_err, 1);
    for (int i = 1; i < 255; i++) push(pix(4, i), 0);
    chk("realign_ready_254", ppu_ready, 1);
    push(pix(4, 255), 0);
    chk("realign_ready_255", ppu_ready, 0);
    clear_flags();
    pix_ptr_y = 0; pix_ptr_x = 0;
    tick();
    chk("realign_tag0", sync_err, 0);
    chk("realign_x0", rgb_buf, 9'h155);
    pix_ptr_x = 200; #1;
    chk("realign_x200", rgb_buf, pix(4, 200));

    // Asynchronous reset mid-line
    for (int i = 0; i < 128; i++) push(pix(5, i), 0);
    reset = 1; pix_ptr_y = 0; #1;
    chk("amid_ready", ppu_ready, 1);
    chk("amid_rgb", rgb_buf, 0);
    chk("amid_sync", sync_err, 0);
    @(posedge pix_clk); #1;
    reset = 0;
    m_reset();
    for (int i = 0; i < 20; i++) push(9'h0F0, 0);
    push(pix(6, 0), 1);
    for (int i = 1; i < 255; i++) push(pix(6, i), 0);
    chk("post_rst_ready_255", ppu_ready, 1);
    push(pix(6, 255), 0);
    chk("post_rst_ready_256", ppu_ready, 0);
    pix_ptr_y = 1; pix_ptr_x = 1;
    tick();
    chk("post_rst_x1", rgb_buf, pix(6, 1));

    // Randomized traffic against the model
    for (int c = 0; c < 6000; c++) begin
      ppu_valid  = ($urandom_range(0, 9) < 8);
      ppu_rgb    = 9'($urandom);
      ppu_sof    = ($urandom_range(0, 399) == 0);
      pix_ptr_x  = 8'($urandom);
      clr_status = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 349) == 0)
        pix_ptr_y = (pix_ptr_y == 8'd239) ? 8'd0 : pix_ptr_y + 8'd1;
      else if ($urandom_range(0, 1999) == 0)
        pix_ptr_y = 8'($urandom_range(0, 239));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
